// File: rtl/ysyx_23060332_wb_arb_if.sv
// Write-back bus between EXU/LSU producers, the IDU hazard query and the register file write port.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline's view.
interface ysyx_23060332_wb_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              exu_valid;
    logic              exu_ready;
    logic [ADDR_W-1:0] exu_waddr;
    logic [DATA_W-1:0] exu_wdata;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_waddr;
    logic [DATA_W-1:0] lsu_wdata;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic              stall;
    logic              reg_wen;
    logic [ADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;

    modport slave (
        input  exu_valid, exu_waddr, exu_wdata,
        input  lsu_valid, lsu_waddr, lsu_wdata,
        input  iss_valid, iss_rd, raddr1, raddr2,
        output exu_ready, lsu_ready, stall,
        output reg_wen, reg_waddr, reg_wdata
    );

    modport master (
        output exu_valid, exu_waddr, exu_wdata,
        output lsu_valid, lsu_waddr, lsu_wdata,
        output iss_valid, iss_rd, raddr1, raddr2,
        input  exu_ready, lsu_ready, stall,
        input  reg_wen, reg_waddr, reg_wdata
    );
endinterface

// File: rtl/ysyx_23060332_wb_arb.sv
// Write-back arbiter: round-robin EXU/LSU merge into one register-file port plus a busy-bit scoreboard.
// Define YSYX_23060332_WB_FWD_EN to let an operand written by reg_wen this cycle bypass its busy bit.
module ysyx_23060332_wb_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic                   clk,
    input logic                   rst,
    ysyx_23060332_wb_arb_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [NREG-1:0]   ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] X0       = {ADDR_W{1'b0}};

    logic              rr_lsu_first_r;
    logic              grant_exu_s;
    logic              grant_lsu_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] xfer_addr_s;
    logic [DATA_W-1:0] xfer_data_s;
    logic              wen_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   clr_mask_s;
    logic [NREG-1:0]   set_mask_s;
    logic [NREG-1:0]   busy_nxt_s;
    logic              fwd1_s;
    logic              fwd2_s;

    // Grant selection: a lone requester wins, contention follows the round-robin pointer.
    always_comb begin
        grant_exu_s = 1'b0;
        grant_lsu_s = 1'b0;
        case ({bus.exu_valid, bus.lsu_valid})
            2'b10: grant_exu_s = 1'b1;
            2'b01: grant_lsu_s = 1'b1;
            2'b11: begin
                if (rr_lsu_first_r) begin
                    grant_lsu_s = 1'b1;
                end else begin
                    grant_exu_s = 1'b1;
                end
            end
            default: begin
                grant_exu_s = 1'b0;
                grant_lsu_s = 1'b0;
            end
        endcase
    end

    assign bus.exu_ready = grant_exu_s;
    assign bus.lsu_ready = grant_lsu_s;
    assign xfer_s        = grant_exu_s | grant_lsu_s;
    assign xfer_addr_s   = grant_lsu_s ? bus.lsu_waddr : bus.exu_waddr;
    assign xfer_data_s   = grant_lsu_s ? bus.lsu_wdata : bus.exu_wdata;

    // Round-robin pointer: flips only on contended cycles so lone transfers do not steal a turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_lsu_first_r <= 1'b1;
        end else if (bus.exu_valid && bus.lsu_valid) begin
            rr_lsu_first_r <= ~rr_lsu_first_r;
        end else begin
            rr_lsu_first_r <= rr_lsu_first_r;
        end
    end

    // Output stage: one-cycle registered write; writes to x0 complete the handshake but never pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_r   <= 1'b0;
            waddr_r <= X0;
            wdata_r <= {DATA_W{1'b0}};
        end else if (xfer_s) begin
            wen_r   <= (xfer_addr_s != X0);
            waddr_r <= xfer_addr_s;
            wdata_r <= xfer_data_s;
        end else begin
            wen_r   <= 1'b0;
            waddr_r <= waddr_r;
            wdata_r <= wdata_r;
        end
    end

    assign bus.reg_wen   = wen_r;
    assign bus.reg_waddr = waddr_r;
    assign bus.reg_wdata = wdata_r;

    // Set mask is applied after the clear mask so a same-cycle issue keeps the register busy.
    assign clr_mask_s = wen_r ? (ONE_HOT0 << waddr_r) : {NREG{1'b0}};
    assign set_mask_s = (bus.iss_valid && (bus.iss_rd != X0)) ? (ONE_HOT0 << bus.iss_rd)
                                                              : {NREG{1'b0}};
    assign busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

`ifdef YSYX_23060332_WB_FWD_EN
    assign fwd1_s = wen_r && (waddr_r == bus.raddr1);
    assign fwd2_s = wen_r && (waddr_r == bus.raddr2);
`else
    assign fwd1_s = 1'b0;
    assign fwd2_s = 1'b0;
`endif

    assign bus.stall = ((bus.raddr1 != X0) && busy_r[bus.raddr1] && !fwd1_s) ||
                       ((bus.raddr2 != X0) && busy_r[bus.raddr2] && !fwd2_s);

endmodule

// File: tb/tb_ysyx_23060332_wb_arb.sv
// Directed bench for the write-back arbiter: reset, single writes, contention, scoreboard and x0 cases.
module tb_ysyx_23060332_wb_arb;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ysyx_23060332_wb_arb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    ysyx_23060332_wb_arb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic fwd_stall_exp;

    initial begin
        checks = 0;
        errors = 0;
`ifdef YSYX_23060332_WB_FWD_EN
        fwd_stall_exp = 1'b0;
`else
        fwd_stall_exp = 1'b1;
`endif
        rst = 1'b1;
        bus.exu_valid = 1'b0; bus.exu_waddr = 5'd0; bus.exu_wdata = 32'd0;
        bus.lsu_valid = 1'b0; bus.lsu_waddr = 5'd0; bus.lsu_wdata = 32'd0;
        bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
        bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;

        // Transfer attempted while reset is held must vanish
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd5; bus.exu_wdata = 32'h0000_00AA;
        bus.raddr1 = 5'd3; bus.raddr2 = 5'd7;
        #1;
        check("rst_wen",   64'(bus.reg_wen),   64'd0);
        check("rst_waddr", 64'(bus.reg_waddr), 64'd0);
        check("rst_wdata", 64'(bus.reg_wdata), 64'd0);
        check("rst_stall", 64'(bus.stall),     64'd0);
        tick();
        rst = 1'b0; bus.exu_valid = 1'b0;
        tick();
        check("rel_wen", 64'(bus.reg_wen), 64'd0);

        // Single EXU write
        bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd5; bus.exu_wdata = 32'h0000_1234;
        #1;
        check("exu_rdy",  64'(bus.exu_ready), 64'd1);
        check("exu_lrdy", 64'(bus.lsu_ready), 64'd0);
        tick();
        bus.exu_valid = 1'b0;
        #1;
        check("exu_wen",   64'(bus.reg_wen),   64'd1);
        check("exu_waddr", 64'(bus.reg_waddr), 64'd5);
        check("exu_wdata", 64'(bus.reg_wdata), 64'h1234);
        check("exu_idle",  64'(bus.exu_ready), 64'd0);

        // Three contended cycles: LSU, EXU, LSU
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd3; bus.exu_wdata = 32'h0000_0033;
        bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd4; bus.lsu_wdata = 32'h0000_0044;
        #1;
        check("c1_lrdy", 64'(bus.lsu_ready), 64'd1);
        check("c1_erdy", 64'(bus.exu_ready), 64'd0);
        tick();
        check("c1_waddr", 64'(bus.reg_waddr), 64'd4);
        check("c1_wdata", 64'(bus.reg_wdata), 64'h44);
        check("c2_erdy",  64'(bus.exu_ready), 64'd1);
        check("c2_lrdy",  64'(bus.lsu_ready), 64'd0);
        tick();
        check("c2_wen",   64'(bus.reg_wen),   64'd1);
        check("c2_waddr", 64'(bus.reg_waddr), 64'd3);
        check("c2_wdata", 64'(bus.reg_wdata), 64'h33);
        check("c3_lrdy",  64'(bus.lsu_ready), 64'd1);
        tick();
        bus.exu_valid = 1'b0; bus.lsu_valid = 1'b0;
        #1;
        check("c3_waddr", 64'(bus.reg_waddr), 64'd4);
        tick();
        check("c_idle_wen", 64'(bus.reg_wen), 64'd0);

        // Lone LSU transfer must not move the pointer; next contention goes to EXU
        bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd10; bus.lsu_wdata = 32'h0000_00A0;
        #1;
        check("solo_lrdy", 64'(bus.lsu_ready), 64'd1);
        tick();
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd12; bus.exu_wdata = 32'd1;
        bus.lsu_valid = 1'b1; bus.lsu_waddr = 5'd12; bus.lsu_wdata = 32'd2;
        #1;
        check("solo_waddr", 64'(bus.reg_waddr), 64'd10);
        check("rr_erdy",    64'(bus.exu_ready), 64'd1);
        check("rr_lrdy",    64'(bus.lsu_ready), 64'd0);
        tick();
        bus.exu_valid = 1'b0;
        #1;
        check("same_d1",   64'(bus.reg_wdata), 64'd1);
        check("same_lrdy", 64'(bus.lsu_ready), 64'd1);
        tick();
        bus.lsu_valid = 1'b0;
        #1;
        check("same_waddr", 64'(bus.reg_waddr), 64'd12);
        check("same_d2",    64'(bus.reg_wdata), 64'd2);
        tick();

        // Scoreboard: rd=7 busy until its write-back lands
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.raddr1 = 5'd7;
        #1;
        check("sb_pre", 64'(bus.stall), 64'd0);
        tick();
        bus.iss_valid = 1'b0;
        #1;
        check("sb_busy1", 64'(bus.stall), 64'd1);
        tick();
        check("sb_busy2", 64'(bus.stall), 64'd1);
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd7; bus.exu_wdata = 32'h0000_0077;
        tick();
        bus.exu_valid = 1'b0;
        #1;
        check("sb_wen",   64'(bus.reg_wen),   64'd1);
        check("sb_waddr", 64'(bus.reg_waddr), 64'd7);
        check("sb_fwd",   64'(bus.stall),     64'(fwd_stall_exp));
        tick();
        check("sb_clear", 64'(bus.stall), 64'd0);

        // Issue and clear of rd=9 in the same cycle: issue wins
        bus.raddr1 = 5'd0;
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd9; bus.exu_wdata = 32'h0000_0099;
        tick();
        bus.exu_valid = 1'b0; bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        #1;
        check("sc_wen9", 64'(bus.reg_waddr), 64'd9);
        tick();
        bus.iss_valid = 1'b0; bus.raddr2 = 5'd9;
        #1;
        check("sc_stall", 64'(bus.stall), 64'd1);

        // x0: handshake without pulse, never busy
        bus.raddr2 = 5'd0;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd0; bus.exu_wdata = 32'hFFFF_FFFF;
        #1;
        check("x0_rdy",   64'(bus.exu_ready), 64'd1);
        check("x0_stall", 64'(bus.stall),     64'd0);
        tick();
        bus.iss_valid = 1'b0; bus.exu_valid = 1'b0;
        #1;
        check("x0_nowen", 64'(bus.reg_wen), 64'd0);
        check("x0_stl2",  64'(bus.stall),   64'd0);

        // Asynchronous reset kills a pending pulse and all busy bits
        bus.raddr2 = 5'd9;
        bus.exu_valid = 1'b1; bus.exu_waddr = 5'd6; bus.exu_wdata = 32'h0000_0066;
        tick();
        bus.exu_valid = 1'b0;
        #1;
        check("ar_wen_pre", 64'(bus.reg_wen), 64'd1);
        check("ar_stl_pre", 64'(bus.stall),   64'd1);
        rst = 1'b1;
        #1;
        check("ar_wen",   64'(bus.reg_wen),   64'd0);
        check("ar_waddr", 64'(bus.reg_waddr), 64'd0);
        check("ar_stall", 64'(bus.stall),     64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("ar_rel_wen", 64'(bus.reg_wen), 64'd0);
        check("ar_rel_stl", 64'(bus.stall),   64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
